pwm_multi_ch: RTL and testbench

Parametrised successor to the single-channel button-driven PWM. It drives CHANNELS independent PWM outputs from one shared period counter, with edge-aligned or center-aligned mode. Each channel's duty is held in a shadow register and updated only at period boundaries, so outputs never glitch. Three debounced buttons set the duty: increment and decrement (both with auto-repeat) and channel-select. Saturation LEDs and a period tick are also provided.

---
 rtl/pwm_multi_ch.sv | 250 +++++++++++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: CHANNELS PWM outputs driven from one shared period counter.
// Edge-aligned or center-aligned counting, with per-channel shadow duty registers
// reloaded at each period boundary. Three debounced buttons (inc/dec with
// auto-repeat, channel select) program the duty of the selected channel.
module pwm_multi_ch #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int PERIOD      = 127,
    parameter int DUTY_INIT   = 64,
    parameter int DEBOUNCE    = 512,
    parameter int REPEAT_DLY  = 4096,
    parameter int REPEAT_RATE = 512,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_inc,
    input  logic                btn_dec,
    input  logic                btn_sel,
    input  logic                mode_center,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [SEL_W-1:0]    sel_ch,
    output logic                at_max,
    output logic                at_min,
    output logic                period_tick
);

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int RP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [WIDTH-1:0] TOP      = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] FULL     = WIDTH'(PERIOD + 1);
    localparam logic [WIDTH-1:0] INIT     = WIDTH'(DUTY_INIT);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [RP_W-1:0]  DLY_LAST = RP_W'(REPEAT_DLY - 1);
    localparam logic [RP_W-1:0]  RPT_LAST = RP_W'(REPEAT_RATE - 1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // ------------------------------------------------------------------
    // Button input path: index 0 = inc, 1 = dec, 2 = sel
    // ------------------------------------------------------------------
    logic [2:0]      btn_raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      acc;
    logic [2:0]      acc_q;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    assign btn_raw = {btn_sel, btn_dec, btn_inc};
    assign press   = acc & ~acc_q;

    // Two-flop synchroniser for the asynchronous button levels
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level once it has differed from the accepted one for DEBOUNCE cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            acc_q <= '0;
            for (int unsigned b = 0; b < 3; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            acc_q <= acc;
            for (int unsigned b = 0; b < 3; b++) begin
                if (sync2[b] == acc[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == DB_LAST) begin
                    db_cnt[b] <= '0;
                    acc[b]    <= sync2[b];
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Auto-repeat for inc/dec
    // ------------------------------------------------------------------
    logic [RP_W-1:0] rep_cnt [2];
    logic [1:0]      rep_armed;
    logic [1:0]      rep_fire;

    // Repeat pulse: first after REPEAT_DLY held cycles, then every REPEAT_RATE
    always_comb begin
        rep_fire = '0;
        for (int unsigned b = 0; b < 2; b++) begin
            if (acc[b] && acc_q[b]) begin
                rep_fire[b] = rep_armed[b] ? (rep_cnt[b] == RPT_LAST)
                                           : (rep_cnt[b] == DLY_LAST);
            end
        end
    end

    // Held-time counter, restarted by the press and by each repeat pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_armed <= '0;
            for (int unsigned b = 0; b < 2; b++) begin
                rep_cnt[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                if (press[b] || !acc[b]) begin
                    rep_cnt[b]   <= '0;
                    rep_armed[b] <= 1'b0;
                end else if (rep_fire[b]) begin
                    rep_cnt[b]   <= '0;
                    rep_armed[b] <= 1'b1;
                end else begin
                    rep_cnt[b] <= rep_cnt[b] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Programmed duties and channel selection
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] duty   [CHANNELS];
    logic [WIDTH-1:0] shadow [CHANNELS];
    logic [WIDTH-1:0] sel_duty;
    logic             inc_step;
    logic             dec_step;

    assign inc_step = press[0] | rep_fire[0];
    assign dec_step = press[1] | rep_fire[1];
    assign sel_duty = duty[sel_ch];

    // Saturating duty steps on the selected channel; sel press advances the channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_ch <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                duty[i] <= INIT;
            end
        end else begin
            if (inc_step && !dec_step && (sel_duty != FULL)) begin
                duty[sel_ch] <= sel_duty + 1'b1;
            end else if (dec_step && !inc_step && (sel_duty != '0)) begin
                duty[sel_ch] <= sel_duty - 1'b1;
            end
            if (press[2]) begin
                sel_ch <= (sel_ch == LAST_SEL) ? '0 : sel_ch + 1'b1;
            end
        end
    end

    // Saturation flags follow the programmed duty of the selected channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            at_max <= 1'b0;
            at_min <= 1'b0;
        end else begin
            at_max <= (sel_duty == FULL);
            at_min <= (sel_duty == '0);
        end
    end

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    dir_t             dir;
    dir_t             dir_nxt;
    logic             mode_q;
    logic             boundary;

    assign boundary = (cnt == '0);

    // Count sequencing; every boundary restarts upward so a mode switch is clean
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (boundary) begin
            cnt_nxt = WIDTH'(1);
            dir_nxt = DIR_UP;
        end else if (!mode_q) begin
            cnt_nxt = (cnt == TOP) ? '0 : cnt + 1'b1;
            dir_nxt = DIR_UP;
        end else if (dir == DIR_UP) begin
            if (cnt == TOP) begin
                cnt_nxt = TOP - 1'b1;
                dir_nxt = DIR_DOWN;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // Counter, direction and mode registers; mode is only taken at the boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            dir    <= DIR_UP;
            mode_q <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
            if (boundary) begin
                mode_q <= mode_center;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow load and outputs
    // ------------------------------------------------------------------
    // At the boundary the compare uses the duty being loaded, so the whole
    // output period (which lags cnt by one cycle) sees one consistent value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_out     <= '0;
            period_tick <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                shadow[i] <= INIT;
            end
        end else begin
            period_tick <= boundary;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (boundary) begin
                    shadow[i]  <= duty[i];
                    pwm_out[i] <= (cnt < duty[i]);
                end else begin
                    pwm_out[i] <= (cnt < shadow[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed self-checking bench for pwm_multi_ch with short debounce/repeat times.
module tb_pwm_multi_ch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       btn_sel = 1'b0;
    logic       mode_center = 1'b0;
    logic [3:0] pwm_out;
    logic [1:0] sel_ch;
    logic       at_max;
    logic       at_min;
    logic       period_tick;

    int passed = 0;
    int total  = 0;
    int hi [4];
    int ticks;

    pwm_multi_ch #(
        .CHANNELS    (4),
        .WIDTH       (8),
        .PERIOD      (15),
        .DUTY_INIT   (8),
        .DEBOUNCE    (4),
        .REPEAT_DLY  (32),
        .REPEAT_RATE (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_inc     (btn_inc),
        .btn_dec     (btn_dec),
        .btn_sel     (btn_sel),
        .mode_center (mode_center),
        .pwm_out     (pwm_out),
        .sel_ch      (sel_ch),
        .at_max      (at_max),
        .at_min      (at_min),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance to the next negedge where period_tick is high (bounded)
    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (!period_tick && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!period_tick) begin
            total++;
            $display("FAIL wait_tick: got no period_tick within %0d cycles, expected one", n);
        end
    endtask

    // Count high cycles per channel and ticks over n cycles, starting at the current negedge
    task automatic measure(input int n);
        for (int c = 0; c < 4; c++) hi[c] = 0;
        ticks = 0;
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clk);
            for (int c = 0; c < 4; c++) if (pwm_out[c]) hi[c]++;
            if (period_tick) ticks++;
        end
    endtask

    task automatic press(input int b, input int on_c, input int off_c);
        if (b == 0) btn_inc = 1'b1;
        if (b == 1) btn_dec = 1'b1;
        if (b == 2) btn_sel = 1'b1;
        repeat (on_c) @(negedge clk);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        btn_sel = 1'b0;
        repeat (off_c) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (pwm_out !== 4'b0000) $display("FAIL rst_pwm: got %b expected 0000", pwm_out); else passed++;
        total++; if (period_tick !== 1'b0) $display("FAIL rst_tick: got %b expected 0", period_tick); else passed++;
        total++; if (sel_ch !== 2'd0) $display("FAIL rst_sel: got %0d expected 0", sel_ch); else passed++;
        total++; if (at_max !== 1'b0) $display("FAIL rst_at_max: got %b expected 0", at_max); else passed++;
        total++; if (at_min !== 1'b0) $display("FAIL rst_at_min: got %b expected 0", at_min); else passed++;
        rst_n = 1'b1;
        wait_tick();
        measure(64);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (hi[c] !== 32) $display("FAIL edge_high ch%0d: got %0d expected 32", c, hi[c]); else passed++;
        end
        total++; if (ticks !== 4) $display("FAIL edge_ticks: got %0d expected 4", ticks); else passed++;
        total++; if (sel_ch !== 2'd0) $display("FAIL edge_sel: got %0d expected 0", sel_ch); else passed++;
        total++; if ({at_max, at_min} !== 2'b00) $display("FAIL edge_flags: got %b expected 00", {at_max, at_min}); else passed++;
    endtask

    task automatic test_inc_debounce();
        int h0 = 0;
        wait_tick();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            btn_inc = ((k < 2) || (k >= 4 && k < 14)) ? 1'b1 : 1'b0;
            if (pwm_out[0]) h0++;
        end
        btn_inc = 1'b0;
        total++; if (h0 !== 8) $display("FAIL inc_same_period: got %0d expected 8", h0); else passed++;
        wait_tick();
        measure(16);
        total++; if (hi[0] !== 9) $display("FAIL inc_ch0: got %0d expected 9", hi[0]); else passed++;
        for (int c = 1; c < 4; c++) begin
            total++;
            if (hi[c] !== 8) $display("FAIL inc_other ch%0d: got %0d expected 8", c, hi[c]); else passed++;
        end
        total++; if ({at_max, at_min} !== 2'b00) $display("FAIL inc_flags: got %b expected 00", {at_max, at_min}); else passed++;
    endtask

    task automatic test_dec_repeat();
        // press lands 6 cycles after assertion; 8 more repeats at +32,+40..+88 bring 9 -> 0
        btn_dec = 1'b1;
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (k == 93) begin
                total++; if (at_min !== 1'b0) $display("FAIL dec_not_yet_min: got %b expected 0", at_min); else passed++;
            end
            if (k == 98) begin
                total++; if (at_min !== 1'b1) $display("FAIL dec_reached_min: got %b expected 1", at_min); else passed++;
            end
        end
        btn_dec = 1'b0;
        repeat (12) @(negedge clk);
        wait_tick();
        measure(16);
        total++; if (hi[0] !== 0) $display("FAIL dec_ch0_low: got %0d expected 0", hi[0]); else passed++;
        total++; if (hi[1] !== 8) $display("FAIL dec_ch1: got %0d expected 8", hi[1]); else passed++;
        total++; if (at_min !== 1'b1) $display("FAIL dec_at_min: got %b expected 1", at_min); else passed++;
    endtask

    task automatic test_select();
        logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            press(2, 8, 8);
            total++;
            if (sel_ch !== exp_sel[i]) $display("FAIL sel_step%0d: got %0d expected %0d", i, sel_ch, exp_sel[i]); else passed++;
            if (i == 0) begin
                total++; if (at_min !== 1'b0) $display("FAIL sel_ch1_at_min: got %b expected 0", at_min); else passed++;
                press(0, 10, 10);
            end
        end
        total++; if (at_min !== 1'b1) $display("FAIL sel_back_ch0_at_min: got %b expected 1", at_min); else passed++;
        wait_tick();
        measure(16);
        total++; if (hi[0] !== 0) $display("FAIL sel_ch0: got %0d expected 0", hi[0]); else passed++;
        total++; if (hi[1] !== 9) $display("FAIL sel_ch1: got %0d expected 9", hi[1]); else passed++;
        total++; if (hi[2] !== 8) $display("FAIL sel_ch2: got %0d expected 8", hi[2]); else passed++;
        total++; if (hi[3] !== 8) $display("FAIL sel_ch3: got %0d expected 8", hi[3]); else passed++;
    endtask

    task automatic test_center();
        int n;
        int idx;
        logic [29:0] obs;
        logic [29:0] expv;
        repeat (3) press(2, 8, 8);
        total++; if (sel_ch !== 2'd3) $display("FAIL ctr_sel3: got %0d expected 3", sel_ch); else passed++;
        press(0, 100, 12);
        total++; if (at_max !== 1'b1) $display("FAIL ctr_at_max: got %b expected 1", at_max); else passed++;
        wait_tick();
        n = 0;
        repeat (5) begin @(negedge clk); n++; end
        mode_center = 1'b1;
        do begin @(negedge clk); n++; end while (!period_tick && n < 100);
        total++; if (n !== 16) $display("FAIL ctr_switch_period: got %0d expected 16", n); else passed++;
        n = 0;
        do begin @(negedge clk); n++; end while (!period_tick && n < 100);
        total++; if (n !== 30) $display("FAIL ctr_period: got %0d expected 30", n); else passed++;
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int j = 0; j < 30; j++) begin
            if (j > 0) @(negedge clk);
            obs[j]  = pwm_out[2];
            idx     = (j <= 15) ? j : 30 - j;
            expv[j] = (idx < 8);
            for (int c = 0; c < 4; c++) if (pwm_out[c]) hi[c]++;
        end
        total++; if (obs !== expv) $display("FAIL ctr_ch2_shape: got %b expected %b", obs, expv); else passed++;
        total++; if (hi[2] !== 15) $display("FAIL ctr_ch2_high: got %0d expected 15", hi[2]); else passed++;
        total++; if (hi[0] !== 0) $display("FAIL ctr_ch0_high: got %0d expected 0", hi[0]); else passed++;
        total++; if (hi[1] !== 17) $display("FAIL ctr_ch1_high: got %0d expected 17", hi[1]); else passed++;
        total++; if (hi[3] !== 30) $display("FAIL ctr_ch3_high: got %0d expected 30", hi[3]); else passed++;
    endtask

    task automatic test_simul_reset();
        mode_center = 1'b0;
        wait_tick();
        wait_tick();
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        repeat (12) @(negedge clk);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        repeat (12) @(negedge clk);
        total++; if (at_max !== 1'b1) $display("FAIL both_no_change: got at_max %b expected 1", at_max); else passed++;
        wait_tick();
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (pwm_out !== 4'b0000) $display("FAIL mid_rst_pwm: got %b expected 0000", pwm_out); else passed++;
        total++; if (period_tick !== 1'b0) $display("FAIL mid_rst_tick: got %b expected 0", period_tick); else passed++;
        total++; if (sel_ch !== 2'd0) $display("FAIL mid_rst_sel: got %0d expected 0", sel_ch); else passed++;
        total++; if ({at_max, at_min} !== 2'b00) $display("FAIL mid_rst_flags: got %b expected 00", {at_max, at_min}); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (period_tick !== 1'b1) $display("FAIL mid_rst_restart: got tick %b expected 1", period_tick); else passed++;
        measure(16);
        for (int c = 0; c < 4; c++) begin
            total++;
            if (hi[c] !== 8) $display("FAIL post_rst ch%0d: got %0d expected 8", c, hi[c]); else passed++;
        end
        total++; if (ticks !== 1) $display("FAIL post_rst_ticks: got %0d expected 1", ticks); else passed++;
    endtask

    initial begin
        test_reset();
        test_inc_debounce();
        test_dec_repeat();
        test_select();
        test_center();
        test_simul_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
